// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Parametrised multi-digit BCD up/down counter with synchronous clear and
// parallel load. At the end of the range it either wraps or saturates.
// A combinational terminal-count output lets several instances be chained
// into a longer decimal counter.
//
// Parameters:
//   DIGITS   - number of BCD digits (1..8); count width is 4*DIGITS
//   SATURATE - 0: wrap at the range end, 1: hold at the range end
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset (clears count/wrap/load_err)
//   en       in   count enable, one step per edge while high
//   up       in   direction, 1 = increment, 0 = decrement
//   clr      in   synchronous clear (highest priority)
//   load     in   synchronous parallel load of din
//   din      in   BCD load value, digit i is din[4i+3:4i]
//   count    out  current BCD value, digit i is count[4i+3:4i]
//   tc       out  combinational terminal count / cascade carry
//   wrap     out  one-cycle pulse: the counter wrapped on the previous edge
//   load_err out  one-cycle pulse: the previous load was rejected
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic         all_nines;
  logic         all_zeros;
  logic         din_ok;
  logic         range_end;
  logic [W-1:0] stepped;
  logic [W-1:0] count_next;
  logic         wrap_next;
  logic         load_err_next;

  // Whole-word digit predicates on the current count, plus a legality check
  // on the load value (every digit must be 0..9).
  always_comb begin
    all_nines = 1'b1;
    all_zeros = 1'b1;
    din_ok    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (count[4*i +: 4] != 4'd0) all_zeros = 1'b0;
      if (din[4*i +: 4] > 4'd9)    din_ok    = 1'b0;
    end
  end

  // Ripple the carry/borrow from digit 0 upward. A digit steps only while
  // every lower digit sits at its roll-over value (9 going up, 0 going down).
  // At the range end this naturally produces the wrapped value.
  always_comb begin
    logic       chain;
    logic [3:0] digit;
    stepped = count;
    chain   = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (chain) begin
        if (up) stepped[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        else    stepped[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      end
      chain = chain & (up ? (digit == 4'd9) : (digit == 4'd0));
    end
  end

  assign range_end = up ? all_nines : all_zeros;

  // Terminal count ignores clr/load so a cascade sees the carry with zero
  // latency regardless of what the local instance does on this edge.
  assign tc = en & range_end;

  // Next-state selection with priority clr > load > en. The pulse outputs
  // default low so they last exactly one cycle.
  always_comb begin
    count_next    = count;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    if (clr) begin
      count_next = '0;
    end else if (load) begin
      if (din_ok) count_next    = din;
      else        load_err_next = 1'b1;
    end else if (en) begin
      if (!range_end) begin
        count_next = stepped;
      end else if (!SATURATE) begin
        count_next = stepped;
        wrap_next  = 1'b1;
      end
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_next;
      wrap     <= wrap_next;
      load_err <= load_err_next;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Directed bench for bcd_updown_counter. Three configurations are exercised:
// a wrapping 2-digit counter, a saturating 2-digit counter, and two 1-digit
// counters cascaded through tc -> en. Expected post-edge results are queued
// when each stimulus step is driven and popped when the edge has happened.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

  localparam time HALF = 5ns;

  logic clk;
  logic reset;

  // wrapping 2-digit instance
  logic       en0, up0, clr0, load0;
  logic [7:0] din0, count0;
  logic       tc0, wrap0, lerr0;

  // saturating 2-digit instance
  logic       en1, up1, clr1, load1;
  logic [7:0] din1, count1;
  logic       tc1, wrap1, lerr1;

  // cascaded pair of 1-digit instances
  logic       casc_en, casc_up;
  logic [3:0] count_lo, count_hi;
  logic       tc_lo, tc_hi, wrap_lo, wrap_hi, lerr_lo, lerr_hi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         sel;
    string      tag;
    logic [7:0] count;
    logic       wrap;
    logic       lerr;
  } exp_t;

  exp_t sb[$];

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) dut (
    .clk(clk), .reset(reset), .en(en0), .up(up0), .clr(clr0), .load(load0),
    .din(din0), .count(count0), .tc(tc0), .wrap(wrap0), .load_err(lerr0)
  );

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .en(en1), .up(up1), .clr(clr1), .load(load1),
    .din(din1), .count(count1), .tc(tc1), .wrap(wrap1), .load_err(lerr1)
  );

  bcd_updown_counter #(.DIGITS(1), .SATURATE(1'b0)) dut_lo (
    .clk(clk), .reset(reset), .en(casc_en), .up(casc_up), .clr(1'b0),
    .load(1'b0), .din(4'd0), .count(count_lo), .tc(tc_lo), .wrap(wrap_lo),
    .load_err(lerr_lo)
  );

  bcd_updown_counter #(.DIGITS(1), .SATURATE(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .en(tc_lo), .up(casc_up), .clr(1'b0),
    .load(1'b0), .din(4'd0), .count(count_hi), .tc(tc_hi), .wrap(wrap_hi),
    .load_err(lerr_hi)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #HALF clk = ~clk;
  end

  // Decimal integer to two-digit BCD.
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((v / 10) % 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  // Observation views per configuration; for the cascade the "lerr" view
  // collects every flag that must never rise while counting 0..25.
  function automatic logic [7:0] obs_count(input int sel);
    case (sel)
      0:       return count0;
      1:       return count1;
      default: return {count_hi, count_lo};
    endcase
  endfunction

  function automatic logic obs_tc(input int sel);
    case (sel)
      0:       return tc0;
      1:       return tc1;
      default: return tc_lo | tc_hi;
    endcase
  endfunction

  function automatic logic obs_wrap(input int sel);
    case (sel)
      0:       return wrap0;
      1:       return wrap1;
      default: return wrap_lo;
    endcase
  endfunction

  function automatic logic obs_lerr(input int sel);
    case (sel)
      0:       return lerr0;
      1:       return lerr1;
      default: return lerr_lo | lerr_hi | wrap_hi;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [7:0] obs,
                           input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the configuration it
  // belongs to.
  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check_val({e.tag, " count"}, obs_count(e.sel), e.count);
      check_val({e.tag, " wrap"}, {7'd0, obs_wrap(e.sel)}, {7'd0, e.wrap});
      check_val({e.tag, " load_err"}, {7'd0, obs_lerr(e.sel)}, {7'd0, e.lerr});
    end
  endtask

  // Drive one step on the chosen configuration (others idle), check tc
  // before the edge, queue the post-edge expectation and check it after.
  task automatic apply_stimulus(input int sel, input logic e, input logic u,
                                input logic c, input logic l,
                                input logic [7:0] d, input logic exp_tc,
                                input logic [7:0] exp_count,
                                input logic exp_wrap, input logic exp_lerr,
                                input string tag);
    exp_t x;
    @(negedge clk);
    en0 = 1'b0; up0 = 1'b1; clr0 = 1'b0; load0 = 1'b0; din0 = 8'h00;
    en1 = 1'b0; up1 = 1'b1; clr1 = 1'b0; load1 = 1'b0; din1 = 8'h00;
    casc_en = 1'b0; casc_up = 1'b1;
    case (sel)
      0: begin en0 = e; up0 = u; clr0 = c; load0 = l; din0 = d; end
      1: begin en1 = e; up1 = u; clr1 = c; load1 = l; din1 = d; end
      default: begin casc_en = e; casc_up = u; end
    endcase
    #1;
    check_val({tag, " tc"}, {7'd0, obs_tc(sel)}, {7'd0, exp_tc});
    x.sel = sel; x.tag = tag; x.count = exp_count;
    x.wrap = exp_wrap; x.lerr = exp_lerr;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    reset = 1'b0;
    en0 = 1'b0; up0 = 1'b1; clr0 = 1'b0; load0 = 1'b0; din0 = 8'h00;
    en1 = 1'b0; up1 = 1'b1; clr1 = 1'b0; load1 = 1'b0; din1 = 8'h00;
    casc_en = 1'b0; casc_up = 1'b1;

    // Reset state, then asynchronous reset in the middle of a clock period.
    repeat (2) @(negedge clk);
    check_val("reset count", count0, 8'h00);
    check_val("reset flags", {6'd0, wrap0, lerr0}, 8'h00);
    reset = 1'b1;
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h37, 1'b0, 8'h37, 1'b0, 1'b0, "load37");
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h37, 1'b0, 1'b1, "load3C");
    #2 reset = 1'b0;
    #1;
    check_val("async reset count", count0, 8'h00);
    check_val("async reset load_err", {7'd0, lerr0}, 8'h00);
    check_val("async reset wrap", {7'd0, wrap0}, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Counting up with a carry into the tens digit.
    for (int k = 1; k <= 10; k++)
      apply_stimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, to_bcd(k), 1'b0, 1'b0, "up10");
    apply_stimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "clr");
    for (int k = 1; k <= 12; k++)
      apply_stimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, to_bcd(k), 1'b0, 1'b0, "up12");

    // Upper range end: tc, clr priority over en, then wrap to zero.
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h98, 1'b0, 8'h98, 1'b0, 1'b0, "load98");
    apply_stimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h99, 1'b0, 1'b0, "inc99");
    apply_stimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, "clr at 99");
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 8'h99, 1'b0, 1'b0, "load99");
    apply_stimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "wrap up");
    apply_stimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, "after wrap");

    // Lower range end, borrow across digits, and direction changes.
    apply_stimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "clr2");
    apply_stimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0, "wrap down");
    apply_stimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h98, 1'b0, 1'b0, "dec98");
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h50, 1'b0, 8'h50, 1'b0, 1'b0, "load50");
    apply_stimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h49, 1'b0, 1'b0, "borrow49");
    apply_stimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0, "turn up50");

    // Load acceptance/rejection and priorities.
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h47, 1'b0, 8'h47, 1'b0, 1'b0, "load47");
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h4A, 1'b0, 8'h47, 1'b0, 1'b1, "load4A");
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h47, 1'b0, 1'b0, "hold47");
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h47, 1'b0, 1'b1, "loadA5");
    apply_stimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, "clr over load");
    apply_stimulus(0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0, "load over en");

    // Saturating instance holds at both range ends.
    apply_stimulus(1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 8'h99, 1'b0, 1'b0, "sat load99");
    for (int k = 0; k < 3; k++)
      apply_stimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0, "sat hold99");
    apply_stimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h98, 1'b0, 1'b0, "sat dec98");
    apply_stimulus(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "sat clr");
    apply_stimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, "sat hold00");

    // Cascade of two single digits from reset.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 25; k++)
      apply_stimulus(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, ((k - 1) % 10) == 9,
                     to_bcd(k), (k % 10) == 0, 1'b0, "cascade");
    #2 reset = 1'b0;
    #1;
    check_val("cascade async reset", {count_hi, count_lo}, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
